mem_arbiter: RTL and testbench

- Shares the single 16-bit-word data memory between two byte-wide requesters.
  - Port 0: CPU control unit.
  - Port 1: loader/DMA engine.
- Serialises requests with a req/ack handshake and round-robin fairness.
- Performs byte-lane selection on reads and byte-lane merge on writes.
- Sits between the requesters and the memory's address, write-data, read-data and write-enable pins.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port byte-wide arbiter in front of a 16-bit-word data memory.
// One-cycle XFER per grant, round-robin or fixed priority on contention.
module mem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_wdata,
    output logic              p0_ack,
    output logic [7:0]        p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_wdata,
    output logic              p1_ack,
    output logic [7:0]        p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_in,
    output logic              mem_we,
    input  logic [15:0]       mem_out,
    output logic              busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state;
    logic                g;
    logic                last_grant;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;

    logic                cand0, cand1;
    logic                grant_any, grant_sel;
    logic [7:0]          rd_byte;

    // The port finishing this cycle still holds its old req, so it cannot compete.
    always_comb begin
        cand0 = p0_req;
        cand1 = p1_req;
        if (state == XFER) begin
            if (g) cand1 = 1'b0;
            else   cand0 = 1'b0;
        end
        grant_any = cand0 | cand1;
        if (cand0 && cand1)
            grant_sel = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        else
            grant_sel = cand1;
    end

    assign rd_byte = addr_q[0] ? mem_out[15:8] : mem_out[7:0];

    // Writes merge the new byte into the current word so the other lane survives.
    always_comb begin
        mem_in = mem_out;
        if (state == XFER) begin
            if (addr_q[0]) mem_in[15:8] = wdata_q;
            else           mem_in[7:0]  = wdata_q;
        end
    end

    assign mem_addr = addr_q;
    assign mem_we   = we_q;
    assign busy     = (state == XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (state == XFER) begin
                if (!g) begin
                    p0_ack <= 1'b1;
                    if (!we_q) p0_rdata <= rd_byte;
                end else begin
                    p1_ack <= 1'b1;
                    if (!we_q) p1_rdata <= rd_byte;
                end
            end
            if (grant_any) begin
                state      <= XFER;
                g          <= grant_sel;
                last_grant <= grant_sel;
                addr_q     <= grant_sel ? p1_addr  : p0_addr;
                we_q       <= grant_sel ? p1_we    : p0_we;
                wdata_q    <= grant_sel ? p1_wdata : p0_wdata;
            end else begin
                state  <= IDLE;
                we_q   <= 1'b0;
                addr_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one
// set of requesters, each with its own behavioural word memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [7:0]  p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;

    logic        p0_ack, p1_ack, mem_we, busy;
    logic [7:0]  p0_rdata, p1_rdata, mem_addr;
    logic [15:0] mem_in, mem_out;

    logic        q_p0_ack, q_p1_ack, q_mem_we, q_busy;
    logic [7:0]  q_p0_rdata, q_p1_rdata, q_mem_addr;
    logic [15:0] q_mem_in, q_mem_out;

    logic [15:0] mem_a [0:127];
    logic [15:0] mem_b [0:127];
    logic        bd_we = 0;
    logic [6:0]  bd_idx = 0;
    logic [15:0] bd_data = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ROUND_ROBIN(1), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we),
        .mem_out(mem_out), .busy(busy)
    );

    mem_arbiter #(.ROUND_ROBIN(0), .ADDR_W(8)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(q_p0_ack), .p0_rdata(q_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(q_p1_ack), .p1_rdata(q_p1_rdata),
        .mem_addr(q_mem_addr), .mem_in(q_mem_in), .mem_we(q_mem_we),
        .mem_out(q_mem_out), .busy(q_busy)
    );

    assign mem_out   = mem_a[mem_addr[7:1]];
    assign q_mem_out = mem_b[q_mem_addr[7:1]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem_a[bd_idx] <= bd_data;
            mem_b[bd_idx] <= bd_data;
        end else begin
            if (mem_we)   mem_a[mem_addr[7:1]]   <= mem_in;
            if (q_mem_we) mem_b[q_mem_addr[7:1]] <= q_mem_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] idx, input logic [15:0] data);
        bd_we = 1; bd_idx = idx; bd_data = data;
        tick();
        bd_we = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick();
        checks++;
        if ({p0_ack, p1_ack, busy, mem_we} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {p0_ack, p1_ack, busy, mem_we});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000", {p0_rdata, p1_rdata, mem_addr});
        end
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_read();
        preload(7'h10, 16'hBEEF);
        p0_req = 1; p0_we = 0; p0_addr = 8'h21;
        tick();
        checks++;
        if ({busy, mem_we, p0_ack, mem_addr} !== {3'b100, 8'h21}) begin
            failures++;
            $display("FAIL read_xfer got=%b_%h exp=100_21", {busy, mem_we, p0_ack}, mem_addr);
        end
        tick();
        checks++;
        if ({p0_ack, p1_ack, mem_we, p0_rdata} !== {3'b100, 8'hBE}) begin
            failures++;
            $display("FAIL read_ack got=%b_%h exp=100_be", {p0_ack, p1_ack, mem_we}, p0_rdata);
        end
        p0_req = 0;
        tick();
        checks++;
        if ({p0_ack, busy, p0_rdata} !== {2'b00, 8'hBE}) begin
            failures++;
            $display("FAIL read_after got=%b_%h exp=00_be", {p0_ack, busy}, p0_rdata);
        end
    endtask

    task automatic test_write();
        p1_req = 1; p1_we = 1; p1_addr = 8'h20; p1_wdata = 8'h5A;
        tick();
        checks++;
        if ({mem_we, busy, mem_in} !== {2'b11, 16'hBE5A}) begin
            failures++;
            $display("FAIL write_merge got=%b_%h exp=11_be5a", {mem_we, busy}, mem_in);
        end
        tick();
        checks++;
        if ({p1_ack, p0_ack, mem_a[7'h10], p1_rdata} !== {2'b10, 16'hBE5A, 8'h00}) begin
            failures++;
            $display("FAIL write_ack got=%b_%h_%h exp=10_be5a_00", {p1_ack, p0_ack}, mem_a[7'h10], p1_rdata);
        end
        p1_req = 0;
        tick();
        checks++;
        if ({p1_ack, mem_we, busy} !== 3'b000) begin
            failures++;
            $display("FAIL write_pulse got=%b exp=000", {p1_ack, mem_we, busy});
        end
    endtask

    task automatic test_back_to_back();
        preload(7'h30, 16'h1122);
        preload(7'h31, 16'h3344);
        p0_req = 1; p0_we = 0; p0_addr = 8'h60;
        p1_req = 1; p1_we = 0; p1_addr = 8'h63;
        tick();
        checks++;
        if ({busy, mem_addr} !== {1'b1, 8'h60}) begin
            failures++;
            $display("FAIL rr_first got=%b_%h exp=1_60", busy, mem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({busy, p0_ack, p1_ack} !== {1'b1, (k % 2 == 0), (k % 2 == 1)}) begin
                failures++;
                $display("FAIL rr_seq%0d got=%b exp=1%b%b", k, {busy, p0_ack, p1_ack},
                         (k % 2 == 0), (k % 2 == 1));
            end
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 16'h2233) begin
            failures++;
            $display("FAIL rr_rdata got=%h exp=2233", {p0_rdata, p1_rdata});
        end
        p0_req = 0; p1_req = 0;
        tick(); tick();
        checks++;
        if ({busy, p0_ack, p1_ack} !== 3'b000) begin
            failures++;
            $display("FAIL rr_idle got=%b exp=000", {busy, p0_ack, p1_ack});
        end
    endtask

    task automatic test_fixed_priority();
        // Make port 0 the last grant in both arbiters, then contend from IDLE.
        p0_req = 1; p0_addr = 8'h60; p0_we = 0;
        tick(); tick();
        p0_req = 0;
        tick();
        p0_req = 1; p1_req = 1; p1_addr = 8'h63; p1_we = 0;
        tick();
        checks++;
        if ({mem_addr, q_mem_addr} !== 16'h6360) begin
            failures++;
            $display("FAIL prio_grant got=%h_%h exp=63_60", mem_addr, q_mem_addr);
        end
        tick();
        checks++;
        if ({q_p0_ack, q_p1_ack, q_mem_addr, p1_ack} !== {2'b10, 8'h63, 1'b1}) begin
            failures++;
            $display("FAIL prio_p1_next got=%b_%h_%b exp=10_63_1", {q_p0_ack, q_p1_ack}, q_mem_addr, p1_ack);
        end
        tick();
        checks++;
        if ({q_p0_ack, q_p1_ack, q_mem_addr, q_p1_rdata} !== {2'b01, 8'h60, 8'h33}) begin
            failures++;
            $display("FAIL prio_no_starve got=%b_%h_%h exp=01_60_33", {q_p0_ack, q_p1_ack}, q_mem_addr, q_p1_rdata);
        end
        p0_req = 0; p1_req = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_xfer();
        preload(7'h02, 16'h1234);
        p1_req = 1; p1_we = 1; p1_addr = 8'h04; p1_wdata = 8'h77;
        tick();
        checks++;
        if ({mem_we, busy} !== 2'b11) begin
            failures++;
            $display("FAIL abort_setup got=%b exp=11", {mem_we, busy});
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({mem_we, busy, p1_ack} !== 3'b000) begin
            failures++;
            $display("FAIL abort_async got=%b exp=000", {mem_we, busy, p1_ack});
        end
        p1_req = 0; p1_we = 0;
        tick();
        checks++;
        if ({mem_a[7'h02], p1_ack, p0_rdata} !== {16'h1234, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL abort_nowrite got=%h_%b_%h exp=1234_0_00", mem_a[7'h02], p1_ack, p0_rdata);
        end
        #2 rst_n = 1;
        p0_req = 1; p0_addr = 8'h61; p1_req = 1; p1_addr = 8'h63;
        tick();
        checks++;
        if (mem_addr !== 8'h61) begin
            failures++;
            $display("FAIL abort_p0_wins got=%h exp=61", mem_addr);
        end
        p1_req = 0;
        tick();
        p0_req = 0;
        tick();
    endtask

    task automatic test_drop();
        p0_req = 1; p0_we = 0; p0_addr = 8'hFF;
        preload(7'h7F, 16'hA55A);
        tick();
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== 8'hA5) begin
            failures++;
            $display("FAIL drop_ack got=%b_%h exp=1_a5", p0_ack, p0_rdata);
        end
        p0_req = 0;
        tick();
        checks++;
        if ({busy, p0_ack, p1_ack, mem_we} !== 4'b0000) begin
            failures++;
            $display("FAIL drop_idle got=%b exp=0000", {busy, p0_ack, p1_ack, mem_we});
        end
        tick();
        checks++;
        if ({busy, p0_ack, p1_ack} !== 3'b000) begin
            failures++;
            $display("FAIL drop_spurious got=%b exp=000", {busy, p0_ack, p1_ack});
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_fixed_priority();
        test_reset_mid_xfer();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
